timing_control_unit: RTL
========================

// Module: timing_control_unit
// PURPOSE
//  Control sequencer downstream of the 4-bit sequence counter. Consumes the live step
//  count (T0..Tn) and the IR opcode, then drives the counter's inc/clear inputs plus all
//  datapath strobes (bus select, register loads, ALU op, memory write) for fetch/decode/execute.
//  Also shadows the counter and stops the CPU on any step desync.
// PARAMETERS
//  SCW      4  width of sc_count and the shadow step register
//  MAX_STEP 7  highest legal step; shadow step > MAX_STEP -> seq_err
// PORTS
//  clk        in   1    clock, rising edge
//  reset      in   1    synchronous, active-high
//  run        in   1    1 = execute instructions; sampled in IDLE and at instruction end
//  sc_count   in   SCW  current step from sequence counter
//  ir_data    in   8    IR contents: [7:4] opcode, [3:0] operand
//  acc_zero   in   1    ACC == 0 flag
//  sc_inc     out  1    advance sequence counter
//  sc_clr     out  1    clear sequence counter (to its module-level clear)
//  bus_sel    out  3    0 none, 1 PC, 2 MEM, 3 IR[3:0], 4 ACC
//  mar_load   out  1    MAR <- bus
//  ir_load    out  1    IR <- bus
//  pc_inc     out  1    PC <- PC+1
//  pc_load    out  1    PC <- bus
//  acc_load   out  1    ACC <- (acc_src_alu ? ALU(ACC,bus) : bus)
//  acc_src_alu out 1    ACC source select
//  alu_sub    out  1    0 add, 1 subtract
//  mem_we     out  1    MEM[MAR] <- bus
//  busy       out  1    state is FETCH, DECODE or EXEC
//  halted     out  1    state is HALT
//  seq_err    out  1    sticky desync flag
// BEHAVIOUR
//  - Registered state {IDLE, FETCH, DECODE, EXEC, HALT}, opcode reg op[3:0], shadow step
//    step_exp[SCW-1:0], seq_err. All strobes are combinational from (state, op, sc_count, acc_zero).
//  - Reset (one edge): state=IDLE, op=0, step_exp=0, seq_err=0. Outputs then: sc_clr=1, all others 0.
//  - sc_inc and sc_clr are mutually exclusive. sc_inc=1 in every FETCH/DECODE/EXEC step that
//    does not assert sc_clr. IDLE: sc_clr=1. HALT: both 0, all strobes 0.
//  - IDLE: run=1 -> FETCH next cycle (SC is 0 there); run=0 -> stay.
//  - FETCH T0: bus_sel=1, mar_load. T1: bus_sel=2, ir_load, pc_inc; -> DECODE.
//  - DECODE T2: op <= ir_data[7:4]; no strobes; -> EXEC.
//  - EXEC (opcode from op; the final step asserts sc_clr, then next state = run ? FETCH : IDLE):
//    0 NOP  T3: sc_clr.
//    1 LDA  T3: bus 3, mar_load. T4: bus 2, acc_load, sc_clr.
//    2 ADD  T3: bus 3, mar_load. T4: bus 2, acc_load, acc_src_alu, alu_sub=0, sc_clr.
//    3 SUB  as ADD with alu_sub=1.
//    4 STA  T3: bus 3, mar_load. T4: bus 4, mem_we, sc_clr.
//    5 LDI  T3: bus 3, acc_load, sc_clr.
//    6 JMP  T3: bus 3, pc_load, sc_clr.
//    7 JZ   T3: if acc_zero: bus 3, pc_load; sc_clr in both cases.
//    F HLT  T3: no strobes, no sc_inc/sc_clr; -> HALT.
//    8-E    executed as NOP.
//  - Shadow step: sc_clr -> step_exp<=0; sc_inc -> step_exp+1. In FETCH/DECODE/EXEC, if
//    sc_count != step_exp or step_exp > MAX_STEP: seq_err<=1, state<=HALT, with all
//    strobes forced 0 that same cycle.
//  - HALT and seq_err are left only by reset. run dropping mid-instruction has no effect
//    until the instruction's sc_clr step.
//  - reset mid-instruction: IDLE next edge; partial strobes are abandoned.
// TESTING
//  - reset, run=1, IR=0x5A (LDI 10): T0 bus=1+mar_load; T1 ir_load+pc_inc; T3 bus=3,
//    acc_load, sc_clr; next cycle FETCH with sc_count=0.
//  - ADD 0x23: T4 bus=2, acc_load=1, acc_src_alu=1, alu_sub=0, sc_clr=1; SUB 0x33 gives alu_sub=1.
//  - JZ 0x79: acc_zero=1 -> pc_load=1, bus=3 at T3; acc_zero=0 -> pc_load=0, sc_clr=1 only.
//  - HLT 0xF0: after T3, halted=1, sc_inc=sc_clr=0 for 20 cycles; run toggling ignored; reset -> IDLE.
//  - Force sc_count=5 during FETCH T1: next cycle seq_err=1, halted=1, all strobes 0.
//  - run=0 during STA T3: T4 completes (mem_we=1), next state IDLE, sc_clr=1, busy=0.

Source files
------------

// File: rtl/timing_control_unit.sv
// Fetch/decode/execute sequencer driven by the external 4-bit step counter.
// Shadows the counter with its own step register and halts the CPU on any desync.
module timing_control_unit #(
  parameter int unsigned SCW      = 4,
  parameter int unsigned MAX_STEP = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  input  logic [SCW-1:0] sc_count,
  input  logic [7:0]     ir_data,
  input  logic           acc_zero,
  output logic           sc_inc,
  output logic           sc_clr,
  output logic [2:0]     bus_sel,
  output logic           mar_load,
  output logic           ir_load,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           acc_load,
  output logic           acc_src_alu,
  output logic           alu_sub,
  output logic           mem_we,
  output logic           busy,
  output logic           halted,
  output logic           seq_err
);

  localparam int unsigned OPW = 4;

  localparam logic [SCW-1:0] STEP_T0  = SCW'(0);
  localparam logic [SCW-1:0] STEP_T1  = SCW'(1);
  localparam logic [SCW-1:0] STEP_T3  = SCW'(3);
  localparam logic [SCW-1:0] STEP_MAX = SCW'(MAX_STEP);

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_PC   = 3'd1;
  localparam logic [2:0] BUS_MEM  = 3'd2;
  localparam logic [2:0] BUS_OPND = 3'd3;
  localparam logic [2:0] BUS_ACC  = 3'd4;

  localparam logic [OPW-1:0] OP_LDA = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_STA = OPW'(4);
  localparam logic [OPW-1:0] OP_LDI = OPW'(5);
  localparam logic [OPW-1:0] OP_JMP = OPW'(6);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(7);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t         state;
  logic [OPW-1:0] op;
  logic [SCW-1:0] step_exp;
  logic           desync;
  logic           operand_unused;

  // The operand nibble is routed to the bus by the datapath, not decoded here.
  assign operand_unused = ^ir_data[3:0];

  assign busy   = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign halted = (state == S_HALT);
  assign desync = busy && ((sc_count != step_exp) || (step_exp > STEP_MAX));

  // Step strobes; a desync cycle drives nothing so the datapath is left untouched.
  always_comb begin
    sc_inc      = 1'b0;
    sc_clr      = 1'b0;
    bus_sel     = BUS_NONE;
    mar_load    = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    acc_load    = 1'b0;
    acc_src_alu = 1'b0;
    alu_sub     = 1'b0;
    mem_we      = 1'b0;
    case (state)
      S_IDLE: sc_clr = 1'b1;
      S_FETCH: begin
        if (!desync) begin
          sc_inc = 1'b1;
          if (sc_count == STEP_T0) begin
            bus_sel  = BUS_PC;
            mar_load = 1'b1;
          end else if (sc_count == STEP_T1) begin
            bus_sel = BUS_MEM;
            ir_load = 1'b1;
            pc_inc  = 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (!desync) sc_inc = 1'b1;
      end
      S_EXEC: begin
        if (!desync) begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              if (sc_count == STEP_T3) begin
                bus_sel  = BUS_OPND;
                mar_load = 1'b1;
              end else begin
                sc_clr = 1'b1;
                if (op == OP_STA) begin
                  bus_sel = BUS_ACC;
                  mem_we  = 1'b1;
                end else begin
                  bus_sel     = BUS_MEM;
                  acc_load    = 1'b1;
                  acc_src_alu = (op != OP_LDA);
                  alu_sub     = (op == OP_SUB);
                end
              end
            end
            OP_LDI: begin
              bus_sel  = BUS_OPND;
              acc_load = 1'b1;
              sc_clr   = 1'b1;
            end
            OP_JMP: begin
              bus_sel = BUS_OPND;
              pc_load = 1'b1;
              sc_clr  = 1'b1;
            end
            OP_JZ: begin
              if (acc_zero) begin
                bus_sel = BUS_OPND;
                pc_load = 1'b1;
              end
              sc_clr = 1'b1;
            end
            OP_HLT: ;
            default: sc_clr = 1'b1;
          endcase
          if (!sc_clr && (op != OP_HLT)) sc_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State, latched opcode, shadow step and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op       <= '0;
      step_exp <= '0;
      seq_err  <= 1'b0;
    end else begin
      if (sc_clr)      step_exp <= '0;
      else if (sc_inc) step_exp <= step_exp + SCW'(1);

      if (desync) begin
        seq_err <= 1'b1;
        state   <= S_HALT;
      end else begin
        case (state)
          S_IDLE:   if (run) state <= S_FETCH;
          S_FETCH:  if (sc_count == STEP_T1) state <= S_DECODE;
          S_DECODE: begin
            op    <= ir_data[7:4];
            state <= S_EXEC;
          end
          S_EXEC: begin
            if (op == OP_HLT)  state <= S_HALT;
            else if (sc_clr)   state <= run ? S_FETCH : S_IDLE;
          end
          S_HALT:   ;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
